gen_gamma_decoder: RTL and testbench

GEN_GAMMA_DECODER -- requirements
Module: gen_gamma_decoder

---
 rtl/gen_gamma_decoder_pkg.sv | 7 +
 rtl/gen_gamma_decoder_if.sv | 20 ++
 rtl/gen_gamma_decoder_fifo.sv | 49 ++++
 rtl/gen_gamma_decoder.sv | 70 +++++++
 tb/tb_gen_gamma_decoder.sv | 183 ++++++++++++++++++
 5 files changed

// File: rtl/gen_gamma_decoder_pkg.sv
// gen_gamma_pkg: shared constants, FIFO state enum and coded-word type for the gamma decoder
package gen_gamma_pkg;
  localparam int SIZE_DEF = 8;
  localparam int DEPTH_DEF = 4;
  typedef enum logic [1:0] {EMPTY, FILL, FULL} fifo_state_t;
  typedef logic [SIZE_DEF:0] coded_word_t;
endpackage

// File: rtl/gen_gamma_decoder_if.sv
// gen_gamma_decoder_if: gamma, coded-word and output handshakes of the gamma decoder
// master drives gam_*/cod_* data+valid and out_ready; slave (the decoder) drives the rest
interface gen_gamma_decoder_if #(parameter int SIZE = 8);
  logic [SIZE-1:0] gam_data;
  logic gam_valid, gam_ready;
  logic [SIZE:0] cod_data;
  logic cod_valid, cod_ready;
  logic [SIZE-1:0] out_data;
  logic out_valid, out_ready;
  logic err;
  logic [15:0] err_cnt;
  modport master (
    output gam_data, gam_valid, cod_data, cod_valid, out_ready,
    input gam_ready, cod_ready, out_data, out_valid, err, err_cnt
  );
  modport slave (
    input gam_data, gam_valid, cod_data, cod_valid, out_ready,
    output gam_ready, cod_ready, out_data, out_valid, err, err_cnt
  );
endinterface

// File: rtl/gen_gamma_decoder_fifo.sv
// gamma_fifo: DEPTH-entry gamma word FIFO with EMPTY/FILL/FULL state machine
// ports: clk, rst (sync, active-high), clr (sync flush), push/din, pop/dout, empty, full
module gamma_fifo
  import gen_gamma_pkg::*;
#(
  parameter int W = 8,
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic push,
  input  logic pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic empty,
  output logic full
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [W-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wr, r_rd;
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  fifo_state_t r_state, w_state_nxt;
  assign w_cnt_nxt = r_cnt + CW'(push) - CW'(pop);
  always_comb begin
    w_state_nxt = FILL;
    w_state_nxt = (w_cnt_nxt == '0) ? EMPTY : (w_cnt_nxt == CW'(DEPTH)) ? FULL : FILL;
  end
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      r_state <= EMPTY;
      r_cnt <= '0;
      r_wr <= '0;
      r_rd <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt <= w_cnt_nxt;
      r_wr <= r_wr + AW'(push);
      r_rd <= r_rd + AW'(pop);
    end
  end
  always_ff @(posedge clk) begin
    if (push) r_mem[r_wr] <= din;
  end
  assign dout = r_mem[r_rd];
  assign empty = (r_state == EMPTY);
  assign full = (r_state == FULL);
endmodule

// File: rtl/gen_gamma_decoder.sv
// gen_gamma_decoder: recovers plaintext as coded sum minus buffered gamma, with carry check
// ports: clk, res_n (sync, active-high reset), flush (sync clear), bus (slave modport of
// gen_gamma_decoder_if). Macro GEN_GAMMA_DECODER_CHECK_EN enables err / err_cnt.
module gen_gamma_decoder
  import gen_gamma_pkg::*;
#(
  parameter int SIZE = SIZE_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input logic clk,
  input logic res_n,
  input logic flush,
  gen_gamma_decoder_if.slave bus
);
  logic w_empty, w_full, w_gam_xfer, w_cod_xfer, r_valid;
  logic [SIZE-1:0] w_g, w_sum, r_data;
  assign w_sum = bus.cod_data[SIZE-1:0];
  // readies are forced to their reset values combinationally while res_n is high
  assign bus.gam_ready = res_n | !w_full;
  assign bus.cod_ready = !res_n & !w_empty & (!r_valid | bus.out_ready);
  assign w_gam_xfer = bus.gam_valid & bus.gam_ready & !res_n & !flush;
  assign w_cod_xfer = bus.cod_valid & bus.cod_ready & !flush;
  gamma_fifo #(.W(SIZE), .DEPTH(DEPTH)) u_fifo (
    .clk(clk),
    .rst(res_n),
    .clr(flush),
    .push(w_gam_xfer),
    .pop(w_cod_xfer),
    .din(bus.gam_data),
    .dout(w_g),
    .empty(w_empty),
    .full(w_full)
  );
  always_ff @(posedge clk) begin
    if (res_n) begin
      r_valid <= 1'b0;
      r_data <= '0;
    end else if (flush) begin
      r_valid <= 1'b0;
    end else if (w_cod_xfer) begin
      r_valid <= 1'b1;
      r_data <= w_sum - w_g;
    end else if (bus.out_ready) begin
      r_valid <= 1'b0;
    end
  end
  assign bus.out_valid = r_valid;
  assign bus.out_data = r_data;
`ifdef GEN_GAMMA_DECODER_CHECK_EN
  logic r_err, w_err;
  logic [15:0] r_err_cnt;
  // carry must match the borrow of the subtraction for a consistent coded word
  assign w_err = bus.cod_data[SIZE] ^ (w_sum < w_g);
  always_ff @(posedge clk) begin
    if (res_n) begin
      r_err <= 1'b0;
      r_err_cnt <= '0;
    end else begin
      if (flush) r_err <= 1'b0;
      else if (w_cod_xfer) r_err <= w_err;
      if (w_cod_xfer && w_err && r_err_cnt != 16'hFFFF) r_err_cnt <= r_err_cnt + 16'd1;
    end
  end
  assign bus.err = r_err;
  assign bus.err_cnt = r_err_cnt;
`else
  assign bus.err = 1'b0;
  assign bus.err_cnt = '0;
`endif
endmodule

// File: tb/tb_gen_gamma_decoder.sv
// tb_gen_gamma_decoder: directed self-checking bench for gen_gamma_decoder (SIZE=8, DEPTH=4)
module tb_gen_gamma_decoder;
  import gen_gamma_pkg::*;
`ifdef GEN_GAMMA_DECODER_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif
  logic clk, res_n, flush;
  int n_cmp, n_bad;
  gen_gamma_decoder_if #(.SIZE(8)) bus ();
  gen_gamma_decoder #(.SIZE(8), .DEPTH(4)) u_dut (
    .clk(clk),
    .res_n(res_n),
    .flush(flush),
    .bus(bus)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    res_n = 1'b1;
    step();
    step();
    #1;
    n_cmp++; if (bus.gam_ready !== 1'b1) begin n_bad++; $display("FAIL rst_gam_ready got %b exp 1", bus.gam_ready); end
    n_cmp++; if (bus.cod_ready !== 1'b0) begin n_bad++; $display("FAIL rst_cod_ready got %b exp 0", bus.cod_ready); end
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL rst_out_valid got %b exp 0", bus.out_valid); end
    n_cmp++; if (bus.out_data !== 8'h00) begin n_bad++; $display("FAIL rst_out_data got %h exp 00", bus.out_data); end
    n_cmp++; if (bus.err_cnt !== 16'h0) begin n_bad++; $display("FAIL rst_err_cnt got %h exp 0000", bus.err_cnt); end
    res_n = 1'b0;
    step();
  endtask

  task automatic decode_one(input logic [7:0] g, input coded_word_t cw, input logic [7:0] exp_d, input logic exp_e, input logic [15:0] exp_cnt, input string nm);
    bus.gam_data = g;
    bus.gam_valid = 1'b1;
    step();
    bus.gam_valid = 1'b0;
    bus.cod_data = cw;
    bus.cod_valid = 1'b1;
    #1;
    n_cmp++; if (bus.cod_ready !== 1'b1) begin n_bad++; $display("FAIL %s_cod_ready got %b exp 1", nm, bus.cod_ready); end
    step();
    bus.cod_valid = 1'b0;
    n_cmp++; if (bus.out_valid !== 1'b1) begin n_bad++; $display("FAIL %s_out_valid got %b exp 1", nm, bus.out_valid); end
    n_cmp++; if (bus.out_data !== exp_d) begin n_bad++; $display("FAIL %s_out_data got %h exp %h", nm, bus.out_data, exp_d); end
    n_cmp++; if (bus.err !== (CHK & exp_e)) begin n_bad++; $display("FAIL %s_err got %b exp %b", nm, bus.err, CHK & exp_e); end
    n_cmp++; if (bus.err_cnt !== (CHK ? exp_cnt : 16'h0)) begin n_bad++; $display("FAIL %s_err_cnt got %h exp %h", nm, bus.err_cnt, CHK ? exp_cnt : 16'h0); end
    step();
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL %s_out_clear got %b exp 0", nm, bus.out_valid); end
  endtask

  task automatic test_decode();
    decode_one(8'h5A, coded_word_t'({1'b1, 8'h10}), 8'hB6, 1'b0, 16'd0, "dec_ok");
    decode_one(8'h5A, coded_word_t'({1'b0, 8'h10}), 8'hB6, 1'b1, 16'd1, "dec_err");
    decode_one(8'h20, coded_word_t'({1'b0, 8'hF0}), 8'hD0, 1'b0, 16'd1, "dec_nob");
  endtask

  task automatic test_stall();
    bus.cod_data = coded_word_t'({1'b0, 8'h33});
    bus.cod_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_cmp++; if (bus.cod_ready !== 1'b0) begin n_bad++; $display("FAIL stall_ready%0d got %b exp 0", i, bus.cod_ready); end
      step();
    end
    bus.gam_data = 8'h01;
    bus.gam_valid = 1'b1;
    #1;
    n_cmp++; if (bus.cod_ready !== 1'b0) begin n_bad++; $display("FAIL stall_push_same got %b exp 0", bus.cod_ready); end
    step();
    bus.gam_valid = 1'b0;
    #1;
    n_cmp++; if (bus.cod_ready !== 1'b1) begin n_bad++; $display("FAIL stall_release got %b exp 1", bus.cod_ready); end
    step();
    bus.cod_valid = 1'b0;
    n_cmp++; if (bus.out_data !== 8'h32 || bus.out_valid !== 1'b1) begin n_bad++; $display("FAIL stall_out got %h/%b exp 32/1", bus.out_data, bus.out_valid); end
    step();
  endtask

  task automatic test_full_hold_flush();
    bus.gam_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.gam_data = 8'((i + 1) * 16);
      step();
    end
    bus.gam_valid = 1'b0;
    #1;
    n_cmp++; if (bus.gam_ready !== 1'b0) begin n_bad++; $display("FAIL full_gam_ready got %b exp 0", bus.gam_ready); end
    bus.out_ready = 1'b0;
    bus.cod_data = coded_word_t'({1'b0, 8'h15});
    bus.cod_valid = 1'b1;
    step();
    n_cmp++; if (bus.out_data !== 8'h05 || bus.out_valid !== 1'b1) begin n_bad++; $display("FAIL hold_first got %h/%b exp 05/1", bus.out_data, bus.out_valid); end
    n_cmp++; if (bus.gam_ready !== 1'b1) begin n_bad++; $display("FAIL hold_gam_ready got %b exp 1", bus.gam_ready); end
    step();
    step();
    n_cmp++; if (bus.out_data !== 8'h05 || bus.out_valid !== 1'b1) begin n_bad++; $display("FAIL hold_keep got %h/%b exp 05/1", bus.out_data, bus.out_valid); end
    n_cmp++; if (bus.cod_ready !== 1'b0) begin n_bad++; $display("FAIL hold_cod_ready got %b exp 0", bus.cod_ready); end
    flush = 1'b1;
    bus.gam_data = 8'h99;
    bus.gam_valid = 1'b1;
    step();
    flush = 1'b0;
    bus.gam_valid = 1'b0;
    bus.out_ready = 1'b1;
    #1;
    n_cmp++; if (bus.out_valid !== 1'b0 || bus.err !== 1'b0) begin n_bad++; $display("FAIL flush_out got %b/%b exp 0/0", bus.out_valid, bus.err); end
    n_cmp++; if (bus.err_cnt !== (CHK ? 16'd1 : 16'd0)) begin n_bad++; $display("FAIL flush_err_cnt got %h exp %h", bus.err_cnt, CHK ? 16'd1 : 16'd0); end
    n_cmp++; if (bus.cod_ready !== 1'b0 || bus.gam_ready !== 1'b1) begin n_bad++; $display("FAIL flush_empty got %b/%b exp 0/1", bus.cod_ready, bus.gam_ready); end
    bus.cod_valid = 1'b0;
    decode_one(8'h77, coded_word_t'({1'b0, 8'h80}), 8'h09, 1'b0, 16'd1, "post_flush");
  endtask

  task automatic test_back_to_back();
    bus.gam_valid = 1'b1;
    bus.gam_data = 8'h01;
    step();
    bus.gam_data = 8'h02;
    step();
    bus.gam_valid = 1'b0;
    bus.cod_data = coded_word_t'({1'b0, 8'h05});
    bus.cod_valid = 1'b1;
    step();
    bus.cod_data = coded_word_t'({1'b1, 8'h01});
    n_cmp++; if (bus.out_data !== 8'h04 || bus.out_valid !== 1'b1) begin n_bad++; $display("FAIL b2b_first got %h/%b exp 04/1", bus.out_data, bus.out_valid); end
    n_cmp++; if (bus.cod_ready !== 1'b1) begin n_bad++; $display("FAIL b2b_ready got %b exp 1", bus.cod_ready); end
    step();
    bus.cod_valid = 1'b0;
    n_cmp++; if (bus.out_data !== 8'hFF || bus.out_valid !== 1'b1) begin n_bad++; $display("FAIL b2b_second got %h/%b exp ff/1", bus.out_data, bus.out_valid); end
    n_cmp++; if (bus.err !== 1'b0) begin n_bad++; $display("FAIL b2b_err got %b exp 0", bus.err); end
    step();
    n_cmp++; if (bus.out_valid !== 1'b0 || bus.cod_ready !== 1'b0) begin n_bad++; $display("FAIL b2b_drain got %b/%b exp 0/0", bus.out_valid, bus.cod_ready); end
  endtask

  task automatic test_mid_reset();
    bus.gam_data = 8'hAA;
    bus.gam_valid = 1'b1;
    step();
    bus.gam_data = 8'hBB;
    step();
    bus.gam_valid = 1'b0;
    bus.cod_data = coded_word_t'({1'b0, 8'hFF});
    bus.cod_valid = 1'b1;
    step();
    bus.cod_valid = 1'b0;
    res_n = 1'b1;
    flush = 1'b1;
    step();
    res_n = 1'b0;
    flush = 1'b0;
    #1;
    n_cmp++; if (bus.out_valid !== 1'b0 || bus.out_data !== 8'h00) begin n_bad++; $display("FAIL mrst_out got %b/%h exp 0/00", bus.out_valid, bus.out_data); end
    n_cmp++; if (bus.err_cnt !== 16'h0 || bus.err !== 1'b0) begin n_bad++; $display("FAIL mrst_err got %b/%h exp 0/0000", bus.err, bus.err_cnt); end
    n_cmp++; if (bus.cod_ready !== 1'b0 || bus.gam_ready !== 1'b1) begin n_bad++; $display("FAIL mrst_fifo got %b/%b exp 0/1", bus.cod_ready, bus.gam_ready); end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    res_n = 1'b1;
    flush = 1'b0;
    bus.gam_data = '0;
    bus.gam_valid = 1'b0;
    bus.cod_data = '0;
    bus.cod_valid = 1'b0;
    bus.out_ready = 1'b1;
    test_reset();
    test_decode();
    test_stall();
    test_full_hold_flush();
    test_back_to_back();
    test_mid_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
